// File: rtl/mac_sequencer_if.sv
// Handshake, operand-memory and MAC-control bundle of the MAC sequencer.
// master = sequencer side, slave = surrounding system (memories, MAC, host).
interface mac_sequencer_if #(
   parameter int Q_INT  = 8,
   parameter int Q_FRAC = 8,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
);
   localparam int QW = Q_INT + Q_FRAC;

   logic              start;
   logic              square;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] x_base;
   logic [ADDR_W-1:0] w_base;
   logic              ready;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] x_addr;
   logic [ADDR_W-1:0] w_addr;
   logic [QW-1:0]     x_rdata;
   logic [QW-1:0]     w_rdata;
   logic [QW-1:0]     mac_x;
   logic [QW-1:0]     mac_w;
   logic              mac_reg_enable;
   logic              mac_x_select;
   logic              mac_w_select;
   logic              mac_acc_loopback;
   logic              mac_acc_update;
   logic [QW-1:0]     acc_in;
   logic [QW-1:0]     result;
   logic              result_valid;
   logic              result_ready;

   modport master (
      input  start, square, len, x_base, w_base, x_rdata, w_rdata, acc_in, result_ready,
      output ready, mem_rd_en, x_addr, w_addr, mac_x, mac_w, mac_reg_enable,
             mac_x_select, mac_w_select, mac_acc_loopback, mac_acc_update,
             result, result_valid
   );

   modport slave (
      output start, square, len, x_base, w_base, x_rdata, w_rdata, acc_in, result_ready,
      input  ready, mem_rd_en, x_addr, w_addr, mac_x, mac_w, mac_reg_enable,
             mac_x_select, mac_w_select, mac_acc_loopback, mac_acc_update,
             result, result_valid
   );
endinterface

// File: rtl/mac_sequencer.sv
// Operand fetch and control sequencer feeding the fixed-point MAC: issues len reads,
// strobes the MAC one cycle later, then presents the accumulator with valid/ready.
module mac_sequencer #(
   parameter int Q_INT  = 8,
   parameter int Q_FRAC = 8,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic            clk,
   input  logic            reset,
   mac_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, LAST, DONE} state_t;

   typedef struct packed {
      logic              square;
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] x_base;
      logic [ADDR_W-1:0] w_base;
   } run_t;

   state_t           state, state_nxt;
   run_t             run_q;
   logic [LEN_W-1:0] cnt;
   logic             zero_q;
   logic             first_q;
   logic             upd_q;
   logic             accept;
   logic             last_issue;

   assign accept     = (state == IDLE) && bus.start;
   assign last_issue = (cnt == run_q.len - LEN_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : ISSUE;
         ISSUE: if (last_issue) state_nxt = LAST;
         LAST:  state_nxt = DONE;
         DONE:  if (bus.result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Run parameters are frozen at the accepting edge; upd_q is the read strobe
   // delayed to line up with the synchronous-read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q   <= '0;
         cnt     <= '0;
         zero_q  <= 1'b0;
         first_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= (state == ISSUE);
         if (accept) begin
            run_q   <= '{square: bus.square, len: bus.len, x_base: bus.x_base, w_base: bus.w_base};
            cnt     <= '0;
            zero_q  <= (bus.len == '0);
            first_q <= 1'b1;
         end else begin
            if (state == ISSUE) cnt <= cnt + LEN_W'(1);
            if (upd_q) first_q <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.ready            = (state == IDLE);
      bus.mem_rd_en        = (state == ISSUE);
      bus.x_addr           = '0;
      bus.w_addr           = '0;
      bus.result_valid     = (state == DONE);
      bus.result           = '0;
      bus.mac_x            = bus.x_rdata;
      bus.mac_w            = bus.w_rdata;
      bus.mac_reg_enable   = 1'b0;
      bus.mac_x_select     = 1'b1;
      bus.mac_w_select     = ~run_q.square;
      bus.mac_acc_update   = upd_q;
      bus.mac_acc_loopback = upd_q & ~first_q;
      if (state == ISSUE) begin
         bus.x_addr = run_q.x_base + ADDR_W'(cnt);
         bus.w_addr = run_q.w_base + ADDR_W'(cnt);
      end
      if (state == DONE && !zero_q) bus.result = bus.acc_in;
   end
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: sync-read memories and a saturating Q8.8 MAC around the DUT,
// a vector table of runs, plus backpressure and mid-run reset sequences.
module tb_mac_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mac_sequencer_if #(.Q_INT(8), .Q_FRAC(8), .ADDR_W(10), .LEN_W(10)) bus ();

   mac_sequencer #(.Q_INT(8), .Q_FRAC(8), .ADDR_W(10), .LEN_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] xmem [1024];
   logic [15:0] wmem [1024];
   logic [15:0] acc;
   int checks = 0;
   int failures = 0;

   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.x_rdata <= xmem[bus.x_addr];
         bus.w_rdata <= wmem[bus.w_addr];
      end
   end

   function automatic logic [15:0] sat(input longint v);
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   function automatic logic [15:0] mac_next(input logic [15:0] a, b, x, input logic wsel, loop);
      longint p, s;
      p = (longint'($signed(x)) * longint'($signed(wsel ? b : x))) >>> 8;
      p = longint'($signed(sat(p)));
      s = loop ? longint'($signed(a)) + p : p;
      return sat(s);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) acc <= 16'h0;
      else if (bus.mac_acc_update)
         acc <= mac_next(acc, bus.mac_w, bus.mac_x, bus.mac_w_select, bus.mac_acc_loopback);
   end
   assign bus.acc_in = acc;

   typedef struct {
      logic        sq;
      int          len;
      logic [9:0]  xb;
      logic [9:0]  wb;
      logic [63:0] xv;
      logic [63:0] wv;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         xmem[v.xb + 10'(i)] = v.xv[i*16 +: 16];
         wmem[v.wb + 10'(i)] = v.wv[i*16 +: 16];
      end
   endtask

   task automatic kick(input logic sq, input int len, input logic [9:0] xb, wb);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.square = sq;
      bus.len    = 10'(len);
      bus.x_base = xb;
      bus.w_base = wb;
      @(posedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int rd_n, up_n, addr_err, loop_err, wsel_err, lat;
      logic seen;
      rd_n = 0; up_n = 0; addr_err = 0; loop_err = 0; wsel_err = 0; lat = 0; seen = 1'b0;
      load(v);
      kick(v.sq, v.len, v.xb, v.wb);
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.len   = 10'h3FF;
         if (bus.mem_rd_en) begin
            if (bus.x_addr !== v.xb + 10'(rd_n) || bus.w_addr !== v.wb + 10'(rd_n)) addr_err++;
            rd_n++;
         end
         if (bus.mac_acc_update) begin
            if (bus.mac_acc_loopback !== (up_n != 0)) loop_err++;
            up_n++;
         end else if (bus.mac_acc_loopback) loop_err++;
         if (bus.mac_w_select !== !v.sq) wsel_err++;
         if (bus.result_valid) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      chk({nm, "_valid_seen"}, 32'(seen), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(v.lat));
      chk({nm, "_result"}, 32'(bus.result), 32'(v.exp));
      chk({nm, "_rd_count"}, 32'(rd_n), 32'(v.len));
      chk({nm, "_upd_count"}, 32'(up_n), 32'(v.len));
      chk({nm, "_addr_err"}, 32'(addr_err), 32'd0);
      chk({nm, "_loop_err"}, 32'(loop_err), 32'd0);
      chk({nm, "_wsel_err"}, 32'(wsel_err), 32'd0);
      if (seen) begin
         bus.result_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.result_ready = 1'b0;
         chk({nm, "_ready_after"}, {30'd0, bus.ready, bus.result_valid}, 32'b10);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ctl"}, {24'd0, bus.ready, bus.mem_rd_en, bus.mac_acc_update, bus.mac_acc_loopback,
                         bus.result_valid, bus.mac_w_select, bus.mac_x_select, bus.mac_reg_enable},
          32'b1000_0110);
      chk({nm, "_addr"}, {12'd0, bus.x_addr, bus.w_addr}, 32'd0);
      chk({nm, "_result"}, 32'(bus.result), 32'd0);
   endtask

   initial begin
      logic seen;
      logic [15:0] held;
      vecs[0] = '{1'b0, 3, 10'h010, 10'h200, {16'h0, 16'h0300, 16'h0200, 16'h0100},
                  {16'h0, 16'h0080, 16'h0080, 16'h0080}, 16'h0300, 5};
      vecs[1] = '{1'b1, 2, 10'h020, 10'h220, {16'h0, 16'h0, 16'h0300, 16'h0200},
                  {16'h0, 16'h0, 16'h1111, 16'h2222}, 16'h0D00, 4};
      vecs[2] = '{1'b0, 0, 10'h030, 10'h230, 64'h0, 64'h0, 16'h0000, 1};
      vecs[3] = '{1'b0, 4, 10'h3FE, 10'h1FE, {4{16'h7F00}}, {4{16'h7F00}}, 16'h7FFF, 6};
      vecs[4] = '{1'b0, 1, 10'h040, 10'h240, {48'h0, 16'h0180}, {48'h0, 16'hFF00}, 16'hFE80, 3};
      vecs[5] = '{1'b0, 2, 10'h050, 10'h250, {32'h0, 16'h8000, 16'h8000},
                  {32'h0, 16'h7F00, 16'h7F00}, 16'h8000, 4};

      for (int i = 0; i < 1024; i++) begin
         xmem[i] = 16'h0;
         wmem[i] = 16'h0;
      end
      bus.start = 1'b0; bus.square = 1'b0; bus.len = '0;
      bus.x_base = '0; bus.w_base = '0; bus.result_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result must hold and a start during DONE must be ignored.
      xmem[10'h080] = 16'h0100; xmem[10'h081] = 16'h0100;
      wmem[10'h280] = 16'h0100; wmem[10'h281] = 16'h0100;
      kick(1'b0, 2, 10'h080, 10'h280);
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.result_valid) seen = 1'b1;
      end
      chk("bp_valid_seen", 32'(seen), 32'd1);
      chk("bp_result", 32'(bus.result), 32'h0200);
      held = bus.result;
      for (int c = 0; c < 4; c++) begin
         bus.start = (c == 1);
         bus.len   = 10'd5;
         @(negedge clk);
         chk($sformatf("bp_hold%0d", c), {14'd0, bus.result_valid, bus.ready, bus.result}, {14'd0, 2'b10, held});
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      chk("bp_ready_after", {30'd0, bus.ready, bus.result_valid}, 32'b10);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp_no_run%0d", c), {30'd0, bus.ready, bus.mem_rd_en}, 32'b10);
      end

      // Reset in cycle 3 of a len=8 square run, then a fresh run.
      kick(1'b1, 8, 10'h100, 10'h300);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy", {30'd0, bus.ready, bus.mem_rd_en}, 32'b01);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_reset");
      chk("mid_acc", 32'(acc), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_vec(vecs[1], "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control and operand-fetch stage directly upstream of the fixed-point MAC unit. On a start request it reads a run of `len` input/weight pairs from two synchronous-read memories. It streams them into the MAC, drives the MAC control strobes, and presents the final saturated accumulator value as a result with a valid/ready handshake. It supports dot-product mode (x·w) and sum-of-squares mode (x·x).

## Interface
Parameters:
- `Q_INT`, 8: integer bits of the signed fixed-point word.
- `Q_FRAC`, 8: fraction bits; word width `QW = Q_INT+Q_FRAC`.
- `ADDR_W`, 10: memory address width.
- `LEN_W`, 10: run-length width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  run request; sampled only while `ready`=1.
- `square`  in  1  sampled with `start`; 1 selects sum of squares.
- `len`  in  LEN_W  number of terms, sampled with `start`.
- `x_base`, `w_base`  in  ADDR_W  first addresses, sampled with `start`.
- `ready`  out  1  idle and able to accept `start`.
- `mem_rd_en`  out  1  read strobe to both memories.
- `x_addr`, `w_addr`  out  ADDR_W  read addresses.
- `x_rdata`, `w_rdata`  in  QW  memory data, valid one cycle after `mem_rd_en`.
- `mac_x`, `mac_w`  out  QW  MAC operands (`x_rdata`, `w_rdata` passthrough).
- `mac_reg_enable`  out  1  always 0.
- `mac_x_select`  out  1  always 1.
- `mac_w_select`  out  1  0 in square mode, else 1.
- `mac_acc_loopback`  out  1  0 on the first term, 1 on later terms.
- `mac_acc_update`  out  1  1 on every cycle that carries a term.
- `acc_in`  in  QW  MAC accumulator output.
- `result`  out  QW  final value.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  downstream accepts `result`.

## Operation
- States: IDLE, ISSUE, LAST, DONE.
- **IDLE:** `ready`=1. If `start`=1, latch `len`, bases, and `square`.
  - If `len`=0, go to DONE with the zero flag set.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `mem_rd_en`=1, `x_addr`=`x_base`+i, `w_addr`=`w_base`+i, for i = 0..len-1.
  - The issue counter increments each cycle.
  - Addresses wrap modulo 2^ADDR_W.
  - After i = len-1 is issued, go to LAST.
- **Data side:** a one-cycle delayed copy of `mem_rd_en` drives `mac_acc_update`. A first-term flag forces `mac_acc_loopback`=0 on the first data cycle; it is 1 on all later data cycles.
- **LAST:** one cycle in which the final term's data is consumed (`mac_acc_update`=1). No read is issued. Go to DONE.
- **DONE:**
  - `result_valid`=1.
  - `result` = `acc_in`, or 0 when the zero flag is set.
  - The MAC holds its value because `mac_acc_update`=0.
  - On `result_valid`&&`result_ready`, return to IDLE.
- Arithmetic: multiplication, saturation, and accumulation are done entirely by the MAC. This block adds no width growth and no rounding.
- `start` outside IDLE is ignored. Inputs are sampled only at the accepting edge; later changes have no effect on the run.
- `mac_acc_update`/`mac_acc_loopback` are 0 in IDLE and DONE.

## Timing
- Reset values:
  - `ready`=1; state IDLE.
  - `mem_rd_en`, `mac_acc_update`, `mac_acc_loopback`, `result_valid` = 0.
  - `x_addr`, `w_addr`, `result` = 0.
  - `mac_w_select`=1.
- Reset mid-run aborts immediately and returns to IDLE. The shared reset clears the MAC accumulator as well. No partial result is ever presented.
- Let edge E0 be the edge that accepts `start`, with cycles numbered after E0:
  - Cycles 1..N: ISSUE.
  - Cycles 2..N+1: MAC update cycles.
  - Cycle N+1: LAST.
  - Cycle N+2: first cycle of `result_valid`.
  - Start-to-valid latency is N+2 cycles.
- `len`=0 → `result_valid` in cycle 1, `result`=0, no MAC strobes.
- `len`=1 → ISSUE lasts one cycle; that single update uses loopback=0.
- Back-to-back runs: `ready` returns the cycle after the handshake. The minimum period is N+3 cycles.
- `result` and `result_valid` are stable while `result_ready`=0.

## Test plan
- **Dot product, Q8.8, len=3:** x = 0x0100, 0x0200, 0x0300; w = 0x0080 each → `result`=0x0300 with `result_valid` in cycle 5. Loopback pattern on update cycles is 0,1,1.
- **Square mode, len=2:** x = 0x0200, 0x0300 → `mac_w_select`=0 and `result`=0x0D00 (13.0).
- **len=0:** `result_valid` in cycle 1 with `result`=0x0000. `mem_rd_en` and `mac_acc_update` never assert.
- **Address wrap and saturation:** `x_base`=0x3FE, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001. Operands all 0x7F00 → `result`=0x7FFF.
- **Backpressure:** hold `result_ready`=0 for 4 cycles and pulse `start` during DONE → `result` is held, the `start` is ignored, and `ready`=1 one cycle after the handshake.
- **Reset mid-run:** assert `reset` in cycle 3 of a len=8 run → all outputs are at reset values immediately. A fresh len=2 run then gives the correct result.
